// File: rtl/countdown_timer_4bit.sv
// countdown_timer_4bit: loadable one-shot down-counter with one-cycle DONE expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload at expiry instead of one-shot.
module countdown_timer_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             RSTB,
    input  logic             ABORT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             ZERO,
    output logic             DONE
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]       state;
    logic [WIDTH-1:0] count;
    logic             terminal;
    assign terminal = (state == RUN) && EN && (count == WIDTH'(1));
    assign Q    = count;
    assign BUSY = (state == RUN);
    assign ZERO = (count == '0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
    always_ff @(posedge Clk or negedge RSTB)
        if (!RSTB)
            reload <= '0;
        else if (!ABORT && LOAD)
            reload <= D;
`endif
    always_ff @(posedge Clk or negedge RSTB)
        if (!RSTB) begin
            count <= '0;
            state <= IDLE;
            DONE  <= 1'b0;
        end else if (ABORT) begin
            count <= '0;
            state <= IDLE;
            DONE  <= 1'b0;
        end else if (LOAD) begin
            count <= D;
            state <= (D != '0) ? RUN : IDLE;
            DONE  <= (D == '0);
        end else if (terminal) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count <= reload;
            state <= RUN;
`else
            count <= '0;
            state <= IDLE;
`endif
            DONE  <= 1'b1;
        end else begin
            count <= (state == RUN && EN) ? count - WIDTH'(1) : count;
            DONE  <= 1'b0;
        end
endmodule

// File: tb/tb_countdown_timer_4bit.sv
// tb_countdown_timer_4bit: table-driven directed check of countdown_timer_4bit, plus async reset sequence.
module tb_countdown_timer_4bit;
    typedef struct {
        logic       abort;
        logic       load;
        logic [3:0] d;
        logic       en;
        logic [3:0] q;
        logic       busy;
        logic       zero;
        logic       done;
    } vec_t;

    logic       Clk = 1'b0;
    logic       RSTB = 1'b0;
    logic       ABORT = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] D = '0;
    logic       EN = 1'b0;
    logic [3:0] Q;
    logic       BUSY, ZERO, DONE;
    int         checks = 0;
    int         fails = 0;
    vec_t       vecs[$];

    countdown_timer_4bit #(.WIDTH(4)) dut (
        .Clk(Clk), .RSTB(RSTB), .ABORT(ABORT), .LOAD(LOAD), .D(D), .EN(EN),
        .Q(Q), .BUSY(BUSY), .ZERO(ZERO), .DONE(DONE)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic [3:0] q, input logic b, input logic z, input logic dn);
        chk({nm, ".Q"}, idx, Q, q);
        chk({nm, ".BUSY"}, idx, {3'b0, BUSY}, {3'b0, b});
        chk({nm, ".ZERO"}, idx, {3'b0, ZERO}, {3'b0, z});
        chk({nm, ".DONE"}, idx, {3'b0, DONE}, {3'b0, dn});
    endtask

    function automatic void add(input logic a, input logic l, input logic [3:0] d, input logic e,
                                input logic [3:0] q, input logic b, input logic z, input logic dn);
        vecs.push_back('{abort: a, load: l, d: d, en: e, q: q, busy: b, zero: z, done: dn});
    endfunction

    initial begin
        // reset held across an edge
        @(negedge Clk);
        @(negedge Clk);
        chk_all("reset", 0, 4'd0, 1'b0, 1'b1, 1'b0);

        // mid-count async reset, checked before any further clock edge
        RSTB = 1'b1;
        LOAD = 1'b1; D = 4'd5;
        @(posedge Clk);
        @(negedge Clk);
        LOAD = 1'b0; D = 4'd0; EN = 1'b1;
        chk_all("preload", 0, 4'd5, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk_all("precount", 0, 4'd4, 1'b1, 1'b0, 1'b0);
        #2 RSTB = 1'b0;
        #1 chk_all("async_rst", 0, 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge Clk);
        RSTB = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk_all("post_rst", i, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        EN = 1'b0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        add(0, 1, 4'd2, 0, 4'd2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add(0, 0, 4'd0, 1, 4'd1, 1, 0, 0);
            add(0, 0, 4'd0, 1, 4'd2, 1, 0, 1);
        end
        add(0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        add(1, 0, 4'd0, 1, 4'd0, 0, 1, 0);
`else
        add(0, 1, 4'd3, 0, 4'd3, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd2, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd1, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd0, 0, 1, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 4'd0, 1, 4'd0, 0, 1, 0);
`endif
        // pause and full range
        add(0, 1, 4'd15, 0, 4'd15, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd14, 1, 0, 0);
        add(0, 0, 4'd0, 0, 4'd14, 1, 0, 0);
        add(0, 0, 4'd0, 0, 4'd14, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd13, 1, 0, 0);
        // priority: reload beats terminal, abort beats load
        add(0, 1, 4'd2, 0, 4'd2, 1, 0, 0);
        add(0, 0, 4'd0, 1, 4'd1, 1, 0, 0);
        add(0, 1, 4'd4, 1, 4'd4, 1, 0, 0);
        add(1, 1, 4'd7, 1, 4'd0, 0, 1, 0);
        add(0, 0, 4'd0, 1, 4'd0, 0, 1, 0);
        // zero load expires immediately, then EN is ignored
        add(0, 1, 4'd0, 0, 4'd0, 0, 1, 1);
        add(0, 0, 4'd0, 1, 4'd0, 0, 1, 0);
        add(0, 0, 4'd0, 1, 4'd0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            ABORT = vecs[i].abort;
            LOAD  = vecs[i].load;
            D     = vecs[i].d;
            EN    = vecs[i].en;
            @(posedge Clk);
            @(negedge Clk);
            chk_all("vec", i, vecs[i].q, vecs[i].busy, vecs[i].zero, vecs[i].done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
